i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
Parametrised, fully synchronous I2C target (slave) with an internal register file. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It supports multi-byte writes and reads with an auto-incrementing register pointer. A host-side port lets local logic read and write the same registers, and receive a pulse on each I2C write.

Parameters:
SLAVE_ADDR, 7'h6B, 7-bit I2C address matched on the bus.
NUM_REGS, 16, number of 8-bit registers; must be a power of 2, range 2..256.
PTR_W, $clog2(NUM_REGS), register pointer width (derived; not overridden).
SYNC_STAGES, 2, synchroniser depth for scl_i/sda_i; minimum 2.

Ports:
clk  input  1  system clock; frequency >= 10x SCL.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  raw SCL pad input.
sda_i  input  1  raw SDA pad input.
sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
host_we  input  1  host register write strobe.
host_addr  input  PTR_W  host register index.
host_wdata  input  8  host write data.
host_rdata  output  8  reg[host_addr], combinational read.
wr_pulse  output  1  one-clk pulse per I2C data byte written.
wr_addr  output  PTR_W  index of last I2C write.
wr_data  output  8  data of last I2C write.
busy  output  1  high from addressed-ACK until STOP or non-matching START.

Behaviour:
- Reset (async, rst_n=0): sda_oe=0, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, pointer=0, all registers=0, FSM=IDLE, synchronisers preset to 1.
- Synchronise scl_i/sda_i through SYNC_STAGES flops. Edges are detected from the last two synchronised samples.
- START/repeated START: SDA falls while SCL=1. STOP: SDA rises while SCL=1.
- Both conditions act from any state. START → ADDR with bit counter=7. STOP → IDLE, sda_oe=0, busy=0.
- Data is sampled on the detected SCL rising edge. sda_oe is updated on the clk after the detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shift 8 bits MSB first.
  - Bits[7:1]==SLAVE_ADDR → ADDR_ACK; drive sda_oe=1 for one SCL period.
  - Mismatch → WAIT_STOP with sda_oe=0 (ignore the bus until the next START or STOP).
- After ADDR_ACK: R/W=0 → PTR; R/W=1 → RDATA with shift register loaded from reg[pointer].
- PTR: receive 8 bits; pointer = byte[PTR_W-1:0] (upper bits ignored). ACK in PTR_ACK, then → WDATA.
- WDATA: receive 8 bits; in WDATA_ACK send ACK and write reg[pointer]. In the same clk:
  - wr_pulse=1; wr_addr/wr_data are updated.
  - Pointer increments modulo NUM_REGS (wraps NUM_REGS-1 → 0).
  - Return to WDATA.
- RDATA: drive sda_oe = ~bit (MSB first) on each SCL falling edge; release SDA after bit 0. Then sample the master ACK in RDATA_ACK:
  - ACK (0): pointer++ (wrapping), reload shift register, → RDATA.
  - NACK (1): pointer++, → WAIT_STOP.
- Repeated START after a PTR write followed by a read address: the pointer is retained (standard register-read sequence).
- Host write and I2C write to the same index in the same clk: the I2C write wins. Host writes to other indices proceed in parallel.
- host_rdata always reflects current register contents.
- A START or STOP mid-byte aborts the byte: a partial byte is never written and the pointer is unchanged.
- Reset asserted mid-transfer: immediate return to reset values, SDA released.
- busy=1 from ADDR_ACK entry until STOP, or until a START is followed by an address mismatch.

Test Plan:
- Write burst: START, 0xD6, ptr 0x03, data 0xA5, 0x5A, STOP → ACK on all 4 bytes, reg[3]=0xA5, reg[4]=0x5A, two wr_pulse (wr_addr 3 then 4), busy low after STOP.
- Register read: host writes reg[7]=0x3C, reg[8]=0xC3. Then START, 0xD6, ptr 0x07, repeated START, 0xD7, read 2 bytes with ACK then NACK, STOP → SDA bits 0x3C then 0xC3, final pointer=9.
- Wrap-around: write ptr 0x0F, data 0x11, 0x22 (NUM_REGS=16) → reg[15]=0x11, reg[0]=0x22.
- Address mismatch: START, 0xA0, data 0xFF, STOP → sda_oe never asserted, no wr_pulse, busy=0, registers unchanged.
- Abort and collision: STOP injected after 4 data bits → no write, pointer unchanged. Host write 0x77 to reg[2] in the same clk as an I2C write of 0x99 to reg[2] → reg[2]=0x99.
- Async reset mid-read (rst_n low while sda_oe=1) → sda_oe=0 immediately, registers cleared, FSM IDLE. The next transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target with an internal 8-bit register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk. START/STOP are recognised from any state.
// Data is sampled on SCL rising edges. sda_oe changes on the clk after a detected SCL falling edge.
// Host port: host_we writes reg[host_addr] in the same clk. An I2C write to the same index in the same clk overrides it.
// wr_pulse is a single-clk strobe that qualifies wr_addr/wr_data. It has no backpressure.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h6B,
  parameter int         NUM_REGS    = 16,
  localparam int        PTR_W       = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_pulse,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic [2:0]             bit_cnt;
  logic                   byte_full;
  logic [7:0]             shreg;
  logic [PTR_W-1:0]       ptr;
  logic                   rd_mode;
  logic                   master_nack;
  logic [7:0]             regs [NUM_REGS];

  logic             scl_s;
  logic             sda_s;
  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             wdata_done;
  logic [PTR_W-1:0] ptr_inc;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // A START is SDA falling while SCL stays high. A STOP is SDA rising while SCL stays high.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  // A complete data byte is committed on the SCL fall that opens its ACK slot.
  // START/STOP cannot coincide with that fall, because both need SCL high.
  assign wdata_done = (state == S_WDATA) && scl_fall && byte_full;
  // The pointer wraps modulo NUM_REGS because NUM_REGS is a power of two.
  assign ptr_inc    = ptr + PTR_W'(1'b1);
  assign host_rdata = regs[host_addr];

  // Synchronise the pads. The chains reset to 1, the idle bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Register file. The I2C write is the later assignment, so it wins on an index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      if (host_we)    regs[host_addr] <= host_wdata;
      if (wdata_done) regs[ptr]       <= shreg;
    end
  end

  // Protocol FSM and its registered outputs.
  // START and STOP take priority over the state-specific handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd7;
      byte_full   <= 1'b0;
      shreg       <= 8'h00;
      ptr         <= '0;
      rd_mode     <= 1'b0;
      master_nack <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      if (start_det) begin
        // A partial byte is dropped here, and the pointer is left untouched.
        state     <= S_ADDR;
        bit_cnt   <= 3'd7;
        byte_full <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= S_IDLE;
        byte_full <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && !byte_full) begin
              shreg <= {shreg[6:0], sda_s};
              if (bit_cnt == 3'd0) byte_full <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end else if (scl_fall && byte_full) begin
              byte_full <= 1'b0;
              if (state == S_ADDR) begin
                if (shreg[7:1] == SLAVE_ADDR) begin
                  state   <= S_ADDR_ACK;
                  sda_oe  <= 1'b1;
                  busy    <= 1'b1;
                  rd_mode <= shreg[0];
                end else begin
                  state  <= S_WAIT_STOP;
                  sda_oe <= 1'b0;
                  busy   <= 1'b0;
                end
              end else if (state == S_PTR) begin
                ptr    <= shreg[PTR_W-1:0];
                state  <= S_PTR_ACK;
                sda_oe <= 1'b1;
              end else begin
                state    <= S_WDATA_ACK;
                sda_oe   <= 1'b1;
                wr_pulse <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= shreg;
                ptr      <= ptr_inc;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rd_mode) begin
                // The first read bit goes out on the fall that ends the ACK slot.
                state  <= S_RDATA;
                shreg  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                state  <= S_PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              state   <= S_WDATA;
              bit_cnt <= 3'd7;
              sda_oe  <= 1'b0;
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                state  <= S_RDATA_ACK;
                sda_oe <= 1'b0;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) master_nack <= sda_s;
            if (scl_fall) begin
              ptr <= ptr_inc;
              if (!master_nack) begin
                state   <= S_RDATA;
                bit_cnt <= 3'd7;
                shreg   <= regs[ptr_inc];
                sda_oe  <= ~regs[ptr_inc][7];
              end else begin
                state  <= S_WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end
          S_IDLE, S_WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile. A bit-banged I2C master drives directed transactions.
// Expected bus responses and write events go into queues; monitor processes pop and compare them.
module tb_i2c_slave_regfile;

  localparam int QTR = 20;  // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = 4'h0;
  logic [7:0] host_wdata = 8'h00;
  logic       sda_oe;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda_line = m_sda & ~sda_oe;

  int total = 0;
  int bad = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_wr_q[$];
  logic [15:0] obs_item;

  // clock / reset
  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (m_scl),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // activity counters for the no-response test
  always @(posedge clk) begin
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
  end

  // write-event monitor
  always @(negedge clk) begin
    if (wr_pulse) begin
      if (exp_wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got=%h expected=none", {4'h0, wr_addr, wr_data});
      end else begin
        check("wr_event", {4'h0, wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
  end

  // bus-response monitor
  always @(negedge clk) begin
    while (obs_q.size() > 0) begin
      obs_item = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL bus_unexpected: got=%h expected=none", obs_item);
      end else begin
        check("bus_resp", obs_item, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic qwait();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; qwait();
    m_scl = 1'b1; qwait();
    qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    b = sda_line; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    logic a;
    exp_q.push_back({8'h01, 7'h00, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    obs_q.push_back({8'h01, 7'h00, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic master_ack);
    logic [7:0] d;
    exp_q.push_back({8'h02, exp_d});
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    obs_q.push_back({8'h02, d});
    send_bit(master_ack);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    host_addr = a;
    #1;
    check(name, {8'h00, host_rdata}, {8'h00, exp});
  endtask

  // Keeps host writes of 0x77 to reg[2] running until the clk of the I2C write.
  task automatic host_collide();
    int n = 0;
    host_addr = 4'h2; host_wdata = 8'h77; host_we = 1'b1;
    while (!wr_pulse && n < 2000) begin
      @(negedge clk);
      n++;
    end
    host_we = 1'b0;
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL collide_timeout: got=no wr_pulse expected=wr_pulse");
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe0;
    int busy0;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    check("rst_wr_data", wr_data, 8'h00);
    check_reg("rst_reg3", 4'h3, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // write burst
    bus_start();
    send_byte(8'hD6, 1'b0);
    check("busy_active", busy, 1'b1);
    send_byte(8'h03, 1'b0);
    exp_wr_q.push_back({8'h03, 8'hA5});
    send_byte(8'hA5, 1'b0);
    exp_wr_q.push_back({8'h04, 8'h5A});
    send_byte(8'h5A, 1'b0);
    bus_stop();
    repeat (10) @(negedge clk);
    check("busy_after_stop", busy, 1'b0);
    check_reg("burst_reg3", 4'h3, 8'hA5);
    check_reg("burst_reg4", 4'h4, 8'h5A);

    // register read with repeated START
    host_write(4'h7, 8'h3C);
    host_write(4'h8, 8'hC3);
    host_write(4'h9, 8'h9E);
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h07, 1'b0);
    bus_start();
    send_byte(8'hD7, 1'b0);
    recv_byte(8'h3C, 1'b0);
    recv_byte(8'hC3, 1'b1);
    bus_stop();
    // The pointer should now be 9.
    bus_start();
    send_byte(8'hD7, 1'b0);
    recv_byte(8'h9E, 1'b1);
    bus_stop();

    // pointer wrap-around
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h0F, 1'b0);
    exp_wr_q.push_back({8'h0F, 8'h11});
    send_byte(8'h11, 1'b0);
    exp_wr_q.push_back({8'h00, 8'h22});
    send_byte(8'h22, 1'b0);
    bus_stop();
    check_reg("wrap_reg15", 4'hF, 8'h11);
    check_reg("wrap_reg0", 4'h0, 8'h22);

    // address mismatch
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'hFF, 1'b1);
    bus_stop();
    repeat (10) @(negedge clk);
    check("nomatch_sda_oe", 16'(oe_cnt - oe0), 16'd0);
    check("nomatch_busy", 16'(busy_cnt - busy0), 16'd0);
    check_reg("nomatch_reg3", 4'h3, 8'hA5);

    // STOP after 4 data bits
    host_write(4'hA, 8'h6E);
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    bus_stop();
    check_reg("abort_reg10", 4'hA, 8'h6E);
    bus_start();
    send_byte(8'hD7, 1'b0);
    recv_byte(8'h6E, 1'b1);
    bus_stop();

    // host/I2C collision on reg[2]
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h02, 1'b0);
    exp_wr_q.push_back({8'h02, 8'h99});
    fork
      send_byte(8'h99, 1'b0);
      host_collide();
    join
    bus_stop();
    check_reg("collide_reg2", 4'h2, 8'h99);

    // async reset while the DUT drives a read bit
    host_write(4'h5, 8'h00);
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h05, 1'b0);
    bus_start();
    send_byte(8'hD7, 1'b0);
    repeat (5) @(negedge clk);
    check("midread_sda_oe", sda_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sda_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check_reg("rst_clear_reg3", 4'h3, 8'h00);
    check_reg("rst_clear_reg2", 4'h2, 8'h00);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus_start();
    send_byte(8'hD6, 1'b0);
    send_byte(8'h01, 1'b0);
    exp_wr_q.push_back({8'h01, 8'h42});
    send_byte(8'h42, 1'b0);
    bus_stop();
    check_reg("post_rst_reg1", 4'h1, 8'h42);

    repeat (20) @(negedge clk);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    check("exp_wr_q_drained", 16'(exp_wr_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
